// File: rtl/pipe_ctrl_pkg.sv
// Shared types and helpers for the pipeline valid/ready sequencer.
// Holds the control FSM encoding and the occupancy popcount.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } pipe_ctrl_state_e;

  // Widest valid-bit vector popcount() accepts; narrower vectors are zero-extended.
  localparam int MAX_STAGES = 64;

  function automatic int unsigned popcount(input logic [MAX_STAGES-1:0] v);
    logic [MAX_STAGES-1:0] rem;
    int unsigned           n;
    rem = v;
    n   = 0;
    for (int i = 0; i < MAX_STAGES; i++) begin
      n   = n + {31'b0, rem[0]};
      rem = rem >> 1;
    end
    return n;
  endfunction

endpackage

// File: rtl/pipe_stall_ctrl.sv
// Valid/ready sequencer for an N-stage register pipeline: per-stage enables,
// valid tracking, bubble collapse, drain handshake and synchronous flush.
module pipe_stall_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int NUM_STAGES      = 3,
  parameter int BUBBLE_COLLAPSE = 1
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              in_valid,
  output logic                              in_ready,
  output logic                              out_valid,
  input  logic                              out_ready,
  input  logic                              drain_req,
  output logic                              drain_done,
  input  logic                              flush,
  output logic [NUM_STAGES-1:0]             stage_en,
  output logic [NUM_STAGES-1:0]             stage_valid,
  output logic [$clog2(NUM_STAGES+1)-1:0]   occupancy
);

  localparam int OCC_W = $clog2(NUM_STAGES + 1);

  pipe_ctrl_state_e      state;
  logic                  adv;
  logic                  accept;
  logic [NUM_STAGES-1:0] en_c;
  logic [NUM_STAGES-1:0] valid_nxt;

  assign adv = out_ready || !stage_valid[NUM_STAGES-1];

  // Each stage may advance if the output drains or any stage at or beyond it
  // is empty; written per stage so the enable has no ripple dependency.
  for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
    if (BUBBLE_COLLAPSE != 0) begin : g_collapse
      assign en_c[k] = adv || !(&stage_valid[NUM_STAGES-1:k]);
    end else begin : g_global
      assign en_c[k] = adv;
    end

    if (k == 0) begin : g_head
      assign valid_nxt[k] = flush ? 1'b0 : (en_c[k] ? accept : stage_valid[k]);
    end else begin : g_body
      assign valid_nxt[k] = flush ? 1'b0 : (en_c[k] ? stage_valid[k-1] : stage_valid[k]);
    end
  end

  // in_ready depends only on state and downstream inputs, never on in_valid.
  assign in_ready   = en_c[0] && (state == RUN) && !drain_req && !flush;
  assign accept     = in_valid && in_ready;
  assign stage_en   = flush ? '1 : en_c;
  assign out_valid  = stage_valid[NUM_STAGES-1];
  assign drain_done = (state == DONE) && drain_req;
  assign occupancy  = OCC_W'(popcount(MAX_STAGES'(stage_valid)));

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stage_valid <= '0;
      state       <= RUN;
    end else begin
      stage_valid <= valid_nxt;
      case (state)
        RUN: begin
          if (drain_req) state <= DRAIN;
        end
        DRAIN: begin
          if (!drain_req)            state <= RUN;
          else if (valid_nxt == '0)  state <= DONE;
        end
        DONE: begin
          if (!drain_req) state <= RUN;
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Self-checking bench: two controllers (collapse on / global enable) share
// stimulus and are compared every cycle against a slot-level pipeline model.
module tb_pipe_stall_ctrl;

  localparam int N      = 3;
  localparam int OW     = $clog2(N + 1);
  localparam int M_RUN  = 0;
  localparam int M_DRAIN = 1;
  localparam int M_DONE = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic in_valid = 1'b0, out_ready = 1'b0, drain_req = 1'b0, flush = 1'b0;

  logic          in_ready_w    [2];
  logic          out_valid_w   [2];
  logic          drain_done_w  [2];
  logic [N-1:0]  stage_en_w    [2];
  logic [N-1:0]  stage_valid_w [2];
  logic [OW-1:0] occupancy_w   [2];

  // Model: each slot holds the id of the item it carries, or -1 when empty.
  int           slot   [2][N];
  int           mode   [2];
  int           dp     [2][N];
  logic [N-1:0] exp_en [2];
  logic         exp_ir [2];
  int           xfers  [2];
  int           in_id = 0;
  logic         dr_state = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pipe_stall_ctrl #(.NUM_STAGES(N), .BUBBLE_COLLAPSE(1)) dut_bc (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_w[0]),
    .out_valid(out_valid_w[0]), .out_ready(out_ready), .drain_req(drain_req),
    .drain_done(drain_done_w[0]), .flush(flush), .stage_en(stage_en_w[0]),
    .stage_valid(stage_valid_w[0]), .occupancy(occupancy_w[0])
  );

  pipe_stall_ctrl #(.NUM_STAGES(N), .BUBBLE_COLLAPSE(0)) dut_gl (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_w[1]),
    .out_valid(out_valid_w[1]), .out_ready(out_ready), .drain_req(drain_req),
    .drain_done(drain_done_w[1]), .flush(flush), .stage_en(stage_en_w[1]),
    .stage_valid(stage_valid_w[1]), .occupancy(occupancy_w[1])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k < N; k++) slot[d][k] = -1;
      mode[d] = M_RUN;
    end
  endtask

  // Expected enables: a stage moves when the output is taken or some slot at
  // or downstream of it is empty (collapse), else only when the tail can move.
  task automatic model_eval();
    for (int d = 0; d < 2; d++) begin
      logic hole;
      hole = 1'b0;
      for (int k = N - 1; k >= 0; k--) begin
        if (slot[d][k] < 0) hole = 1'b1;
        exp_en[d][k] = (d == 0) ? (out_ready || hole) : (out_ready || slot[d][N-1] < 0);
      end
      exp_ir[d] = exp_en[d][0] && mode[d] == M_RUN && !drain_req && !flush;
      if (flush) exp_en[d] = '1;
    end
  endtask

  task automatic set_in(input logic iv, input logic orr, input logic dr, input logic fl);
    in_valid  = iv;
    out_ready = orr;
    drain_req = dr;
    flush     = fl;
    in_id     = in_id + 1;
  endtask

  // One clock: compare at negedge, advance model and bench datapath after posedge.
  task automatic tick();
    logic [N-1:0] en_s [2];
    int nslot [2][N];
    int nmode [2];
    int id_s;
    @(negedge clk);
    model_eval();
    id_s = in_id;
    for (int d = 0; d < 2; d++) begin
      int occ;
      logic [N-1:0] sv;
      logic empty;
      occ = 0;
      for (int k = 0; k < N; k++) begin
        sv[k] = (slot[d][k] >= 0);
        if (slot[d][k] >= 0) occ++;
      end
      check($sformatf("d%0d stage_en", d), 32'(stage_en_w[d]), 32'(exp_en[d]));
      check($sformatf("d%0d stage_valid", d), 32'(stage_valid_w[d]), 32'(sv));
      check($sformatf("d%0d in_ready", d), 32'(in_ready_w[d]), 32'(exp_ir[d]));
      check($sformatf("d%0d out_valid", d), 32'(out_valid_w[d]), 32'(slot[d][N-1] >= 0));
      check($sformatf("d%0d occupancy", d), 32'(occupancy_w[d]), occ);
      check($sformatf("d%0d drain_done", d), 32'(drain_done_w[d]),
            32'(mode[d] == M_DONE && drain_req));
      if (slot[d][N-1] >= 0) check($sformatf("d%0d out_data", d), dp[d][N-1], slot[d][N-1]);
      if (out_valid_w[d] && out_ready) xfers[d]++;
      en_s[d] = stage_en_w[d];

      for (int k = N - 1; k >= 1; k--) nslot[d][k] = exp_en[d][k] ? slot[d][k-1] : slot[d][k];
      nslot[d][0] = exp_en[d][0] ? ((exp_ir[d] && in_valid) ? id_s : -1) : slot[d][0];
      if (flush) for (int k = 0; k < N; k++) nslot[d][k] = -1;
      empty = 1'b1;
      for (int k = 0; k < N; k++) if (nslot[d][k] >= 0) empty = 1'b0;
      case (mode[d])
        M_RUN:   nmode[d] = drain_req ? M_DRAIN : M_RUN;
        M_DRAIN: nmode[d] = !drain_req ? M_RUN : (empty ? M_DONE : M_DRAIN);
        default: nmode[d] = drain_req ? M_DONE : M_RUN;
      endcase
    end
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      mode[d] = nmode[d];
      for (int k = N - 1; k >= 1; k--) if (en_s[d][k]) dp[d][k] = dp[d][k-1];
      if (en_s[d][0]) dp[d][0] = id_s;
      for (int k = 0; k < N; k++) slot[d][k] = nslot[d][k];
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1);
  end

  initial begin
    model_reset();
    for (int d = 0; d < 2; d++) begin
      xfers[d] = 0;
      for (int k = 0; k < N; k++) dp[d][k] = 0;
    end

    // Reset held for three cycles, released away from the clock edge.
    #1 reset = 1'b0;
    repeat (3) @(posedge clk);
    #3 reset = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("rst d%0d stage_valid", d), 32'(stage_valid_w[d]), 32'h0);
      check($sformatf("rst d%0d stage_en", d), 32'(stage_en_w[d]), 32'h7);
      check($sformatf("rst d%0d in_ready", d), 32'(in_ready_w[d]), 32'h1);
      check($sformatf("rst d%0d out_valid", d), 32'(out_valid_w[d]), 32'h0);
      check($sformatf("rst d%0d occupancy", d), 32'(occupancy_w[d]), 32'h0);
      check($sformatf("rst d%0d drain_done", d), 32'(drain_done_w[d]), 32'h0);
    end

    // Streaming: first out_valid two edges after the first accept.
    set_in(1, 1, 0, 0);
    tick(); check("stream out_valid e1", 32'(out_valid_w[0]), 32'h0);
    set_in(1, 1, 0, 0);
    tick(); check("stream out_valid e2", 32'(out_valid_w[0]), 32'h0);
    set_in(1, 1, 0, 0);
    tick(); check("stream out_valid e3", 32'(out_valid_w[0]), 32'h1);
    for (int c = 0; c < 7; c++) begin
      set_in(1, 1, 0, 0);
      tick();
      check("stream occupancy", 32'(occupancy_w[0]), 32'h3);
    end
    repeat (3) begin set_in(0, 1, 0, 0); tick(); end

    // Bubble collapse: build 101, then stall with a waiting input.
    set_in(1, 0, 0, 0); tick();
    set_in(0, 0, 0, 0); tick();
    set_in(1, 0, 0, 0); tick();
    check("bubble d0 stage_valid", 32'(stage_valid_w[0]), 32'h5);
    check("bubble d1 stage_valid", 32'(stage_valid_w[1]), 32'h5);
    set_in(1, 0, 0, 0);
    #2;
    check("bubble d0 stage_en", 32'(stage_en_w[0]), 32'h3);
    check("bubble d0 in_ready", 32'(in_ready_w[0]), 32'h1);
    check("global d1 stage_en", 32'(stage_en_w[1]), 32'h0);
    check("global d1 in_ready", 32'(in_ready_w[1]), 32'h0);
    tick();
    check("bubble d0 stage_valid next", 32'(stage_valid_w[0]), 32'h7);
    check("global d1 stage_valid hold", 32'(stage_valid_w[1]), 32'h5);
    check("bubble d0 stage_en full", 32'(stage_en_w[0]), 32'h0);
    check("bubble d0 in_ready full", 32'(in_ready_w[0]), 32'h0);

    // Drain a full pipe.
    repeat (3) begin set_in(0, 1, 0, 0); tick(); end
    repeat (3) begin set_in(1, 0, 0, 0); tick(); end
    check("drain pre d0 stage_valid", 32'(stage_valid_w[0]), 32'h7);
    check("drain pre d1 stage_valid", 32'(stage_valid_w[1]), 32'h7);
    xfers[0] = 0;
    set_in(1, 1, 1, 0);
    #2;
    check("drain in_ready", 32'(in_ready_w[0]), 32'h0);
    tick();
    set_in(1, 1, 1, 0); tick();
    check("drain done e2", 32'(drain_done_w[0]), 32'h0);
    set_in(1, 1, 1, 0); tick();
    check("drain done e3", 32'(drain_done_w[0]), 32'h1);
    check("drain stage_valid", 32'(stage_valid_w[0]), 32'h0);
    check("drain transfers", xfers[0], 3);
    set_in(1, 1, 0, 0);
    #2;
    check("drain release done", 32'(drain_done_w[0]), 32'h0);
    check("drain release in_ready", 32'(in_ready_w[0]), 32'h0);
    tick();
    check("drain resume in_ready", 32'(in_ready_w[0]), 32'h1);

    // Flush under stall with a pending input.
    repeat (3) begin set_in(1, 0, 0, 0); tick(); end
    check("flush pre stage_valid", 32'(stage_valid_w[0]), 32'h7);
    set_in(1, 0, 0, 1);
    #2;
    check("flush in_ready", 32'(in_ready_w[0]), 32'h0);
    check("flush stage_en", 32'(stage_en_w[0]), 32'h7);
    check("flush d1 stage_en", 32'(stage_en_w[1]), 32'h7);
    tick();
    check("flush stage_valid", 32'(stage_valid_w[0]), 32'h0);
    check("flush out_valid", 32'(out_valid_w[0]), 32'h0);
    check("flush occupancy", 32'(occupancy_w[0]), 32'h0);

    // Asynchronous reset between edges with 110 in flight.
    set_in(1, 0, 0, 0); tick();
    set_in(1, 0, 0, 0); tick();
    set_in(0, 0, 0, 0); tick();
    check("areset pre stage_valid", 32'(stage_valid_w[0]), 32'h6);
    #2 reset = 1'b0;
    #1;
    check("areset d0 stage_valid", 32'(stage_valid_w[0]), 32'h0);
    check("areset d1 stage_valid", 32'(stage_valid_w[1]), 32'h0);
    model_reset();
    repeat (2) @(posedge clk);
    #3 reset = 1'b1;
    #1;
    check("areset in_ready", 32'(in_ready_w[0]), 32'h1);
    check("areset drain_done", 32'(drain_done_w[0]), 32'h0);

    // Randomized traffic with drain bursts and occasional flushes.
    for (int c = 0; c < 2500; c++) begin
      if ($urandom_range(0, 99) < 4) dr_state = !dr_state;
      set_in($urandom_range(0, 99) < 70, $urandom_range(0, 99) < 60, dr_state,
             $urandom_range(0, 99) < 3);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
